playback_sequencer: RTL and testbench

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

---
 rtl/playback_sequencer.sv | 125 ++++++++++++
 tb/tb_playback_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// Playback sequencer: records a step pointer into a sequence RAM and loops playback over 0..loop_end.
// Optional macro PLAYBACK_SEQ_AUTOSTOP_EN stops recording at MAX_ADDR and raises a sticky overflow.
module playback_sequencer #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned MAX_ADDR = (2 ** ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              record,
  input  logic              replay,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] loop_end,
  output logic              write_en,
  output logic [1:0]        state,
  output logic              wrapped,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REC  = 2'b01,
    S_PLAY = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDR);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t state_q;
  state_t state_nxt_c;
  logic   stop_hit_c;

  assign state = state_q;

`ifdef PLAYBACK_SEQ_AUTOSTOP_EN
  logic lock;
  logic overflow_q;

  assign stop_hit_c = (state_q == S_REC) && tick && (addr == LAST);
  assign overflow   = overflow_q;
`else
  assign stop_hit_c = 1'b0;
  assign overflow   = 1'b0;
`endif

  // Next state: clear, then record, then replay, otherwise idle
  always_comb begin
    state_nxt_c = S_IDLE;
    if (clear) begin
      state_nxt_c = S_IDLE;
    end else if (record) begin
      state_nxt_c = S_REC;
`ifdef PLAYBACK_SEQ_AUTOSTOP_EN
      // After an overrun, record must be released before recording resumes
      if (lock || stop_hit_c) state_nxt_c = S_IDLE;
`endif
    end else if (replay) begin
      state_nxt_c = S_PLAY;
    end
  end

  // Pointer, loop length and flags; tick acts on the pre-edge state
  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      loop_end <= '0;
      state_q  <= S_IDLE;
      write_en <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      wrapped  <= 1'b0;
      state_q  <= state_nxt_c;
      write_en <= (state_nxt_c == S_REC);
      if (clear) begin
        addr     <= '0;
        loop_end <= '0;
      end else begin
        case (state_q)
          S_REC: begin
            if (tick) begin
              if (addr > loop_end) loop_end <= addr;
              if (addr == LAST) begin
`ifdef PLAYBACK_SEQ_AUTOSTOP_EN
                addr <= addr;
`else
                addr <= '0;
`endif
              end else begin
                addr <= addr + ONE;
              end
            end
          end
          S_PLAY: begin
            // addr beyond loop_end can remain after an aborted record; treat it as a wrap
            if (tick) begin
              if (addr >= loop_end) begin
                addr    <= '0;
                wrapped <= 1'b1;
              end else begin
                addr <= addr + ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PLAYBACK_SEQ_AUTOSTOP_EN
  // Overrun flag and record lock, both released by clear or reset
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overflow_q <= 1'b0;
      lock       <= 1'b0;
    end else begin
      if (stop_hit_c) overflow_q <= 1'b1;
      if (!record) lock <= 1'b0;
      else if (stop_hit_c) lock <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_playback_sequencer.sv
// Self-checking bench for playback_sequencer: directed vector table plus reset and overrun sequences.
module tb_playback_sequencer;

  localparam int unsigned AW = 11;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  logic reset;
  logic tick, record, replay, clear;
  logic [AW-1:0] addr, loop_end;
  logic write_en, wrapped, overflow;
  logic [1:0] state;

  logic tick_s, record_s, replay_s, clear_s;
  logic [SW-1:0] addr_s, loop_end_s;
  logic write_en_s, wrapped_s, overflow_s;
  logic [1:0] state_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  playback_sequencer #(.ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .record(record), .replay(replay), .clear(clear),
    .addr(addr), .loop_end(loop_end), .write_en(write_en), .state(state),
    .wrapped(wrapped), .overflow(overflow)
  );

  playback_sequencer #(.ADDR_W(SW)) u_small (
    .clk(clk), .reset(reset), .tick(tick_s), .record(record_s), .replay(replay_s), .clear(clear_s),
    .addr(addr_s), .loop_end(loop_end_s), .write_en(write_en_s), .state(state_s),
    .wrapped(wrapped_s), .overflow(overflow_s)
  );

  typedef struct {
    logic clr, rec, rep, tck;
    int   e_addr, e_le;
    logic [1:0] e_st;
    logic e_we, e_wr;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic c, logic r, logic p, logic t, int a, int l,
                              logic [1:0] s, logic w, logic wr);
    vec_t v;
    v.clr = c; v.rec = r; v.rep = p; v.tck = t;
    v.e_addr = a; v.e_le = l; v.e_st = s; v.e_we = w; v.e_wr = wr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_main(input string tag, input int a, input int l, input logic [1:0] s,
                            input logic w, input logic wr, input logic ov);
    check({tag, " addr"}, 32'(addr), 32'(a));
    check({tag, " loop_end"}, 32'(loop_end), 32'(l));
    check({tag, " state"}, 32'(state), 32'(s));
    check({tag, " write_en"}, 32'(write_en), 32'(w));
    check({tag, " wrapped"}, 32'(wrapped), 32'(wr));
    check({tag, " overflow"}, 32'(overflow), 32'(ov));
  endtask

  task automatic check_small(input string tag, input int a, input int l, input logic [1:0] s,
                             input logic w, input logic ov);
    check({tag, " addr"}, 32'(addr_s), 32'(a));
    check({tag, " loop_end"}, 32'(loop_end_s), 32'(l));
    check({tag, " state"}, 32'(state_s), 32'(s));
    check({tag, " write_en"}, 32'(write_en_s), 32'(w));
    check({tag, " overflow"}, 32'(overflow_s), 32'(ov));
  endtask

  task automatic step_main(input logic c, input logic r, input logic p, input logic t);
    @(negedge clk);
    clear = c; record = r; replay = p; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic step_small(input logic c, input logic r, input logic t);
    @(negedge clk);
    clear_s = c; record_s = r; tick_s = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // IDLE=0, REC=1, PLAY=2
    vecs[0]  = mk(0, 1, 0, 0, 0, 0, 2'd1, 1, 0);
    vecs[1]  = mk(0, 1, 0, 1, 1, 0, 2'd1, 1, 0);
    vecs[2]  = mk(0, 1, 0, 1, 2, 1, 2'd1, 1, 0);
    vecs[3]  = mk(0, 1, 0, 1, 3, 2, 2'd1, 1, 0);
    vecs[4]  = mk(0, 1, 0, 1, 4, 3, 2'd1, 1, 0);
    vecs[5]  = mk(0, 1, 0, 1, 5, 4, 2'd1, 1, 0);
    vecs[6]  = mk(0, 0, 1, 0, 5, 4, 2'd2, 0, 0);
    vecs[7]  = mk(0, 0, 1, 1, 0, 4, 2'd2, 0, 1);
    vecs[8]  = mk(0, 0, 1, 1, 1, 4, 2'd2, 0, 0);
    vecs[9]  = mk(0, 0, 1, 1, 2, 4, 2'd2, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 3, 4, 2'd2, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 4, 4, 2'd2, 0, 0);
    vecs[12] = mk(0, 0, 1, 1, 0, 4, 2'd2, 0, 1);
    vecs[13] = mk(0, 0, 1, 1, 1, 4, 2'd2, 0, 0);
    vecs[14] = mk(0, 0, 1, 0, 1, 4, 2'd2, 0, 0);
    vecs[15] = mk(0, 0, 1, 1, 2, 4, 2'd2, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 3, 4, 2'd2, 0, 0);
    vecs[17] = mk(1, 0, 1, 1, 0, 0, 2'd0, 0, 0);
    vecs[18] = mk(0, 0, 1, 0, 0, 0, 2'd2, 0, 0);
    vecs[19] = mk(0, 1, 1, 0, 0, 0, 2'd1, 1, 0);
    vecs[20] = mk(0, 1, 1, 1, 1, 0, 2'd1, 1, 0);
    vecs[21] = mk(0, 0, 1, 0, 1, 0, 2'd2, 0, 0);
    vecs[22] = mk(0, 0, 1, 1, 0, 0, 2'd2, 0, 1);
    vecs[23] = mk(0, 1, 0, 1, 0, 0, 2'd1, 1, 1);
    vecs[24] = mk(0, 1, 0, 1, 1, 0, 2'd1, 1, 0);
    vecs[25] = mk(0, 0, 0, 0, 1, 0, 2'd0, 0, 0);
    vecs[26] = mk(0, 0, 0, 1, 1, 0, 2'd0, 0, 0);

    // Reset dominates active inputs
    reset = 1'b1;
    tick = 1'b1; record = 1'b1; replay = 1'b1; clear = 1'b0;
    tick_s = 1'b1; record_s = 1'b1; replay_s = 1'b0; clear_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_main("reset", 0, 0, 2'd0, 0, 0, 0);
    check_small("reset_s", 0, 0, 2'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick = 1'b0; record = 1'b0; replay = 1'b0;
    tick_s = 1'b0; record_s = 1'b0;

    for (int i = 0; i < 27; i++) begin
      step_main(vecs[i].clr, vecs[i].rec, vecs[i].rep, vecs[i].tck);
      check_main($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_le, vecs[i].e_st,
                 vecs[i].e_we, vecs[i].e_wr, 1'b0);
    end

    // Reset mid-record at addr 6
    step_main(1, 0, 0, 0);
    step_main(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step_main(0, 1, 0, 1);
    check_main("rec6", 6, 5, 2'd1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_main("midrec_reset", 0, 0, 2'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("midrec_reset_hold write_en", 32'(write_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    record = 1'b0; tick = 1'b0;

    // Overrun on the 3-bit instance: nine ticks while recording
    step_small(0, 1, 0);
    for (int i = 0; i < 8; i++) step_small(0, 1, 1);
`ifdef PLAYBACK_SEQ_AUTOSTOP_EN
    check_small("ovr_t8", 7, 7, 2'd0, 0, 1);
    step_small(0, 1, 1);
    check_small("ovr_t9", 7, 7, 2'd0, 0, 1);
    step_small(0, 0, 0);
    check_small("ovr_release", 7, 7, 2'd0, 0, 1);
    step_small(0, 1, 0);
    check_small("ovr_rearm", 7, 7, 2'd1, 1, 1);
`else
    check_small("ovr_t8", 0, 7, 2'd1, 1, 0);
    step_small(0, 1, 1);
    check_small("ovr_t9", 1, 7, 2'd1, 1, 0);
    step_small(0, 0, 0);
    check_small("ovr_release", 1, 7, 2'd0, 0, 0);
`endif
    step_small(1, 1, 1);
    check_small("ovr_clear", 0, 0, 2'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
